// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch path.
package mips_pkg;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_LOAD
  } imem_state_t;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Byte address is bad when misaligned or beyond the 2**addr_w word array.
  function automatic logic addr_fault(logic [31:0] addr, int unsigned addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module imem_ram #(
  parameter int unsigned AddrW = 8,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [2**AddrW];

  // Read-before-write when both ports hit the same word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/instr_mem.sv
// Loadable synchronous instruction memory with clear sequencer and fetch fault detection.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module instr_mem
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_rdy,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned RAM_W = DATA_W + 1;
`else
  localparam int unsigned RAM_W = DATA_W;
`endif

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  imem_state_t       state;
  logic [ADDR_W-1:0] ptr;
  logic              nop_sel;
  logic              fetch_acc;
  logic              addr_bad;
  logic              last_beat;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] wr_word;
  logic [RAM_W-1:0]  ram_wdata;
  logic [RAM_W-1:0]  ram_rdata;

  assign fetch_rdy  = (state == S_IDLE);
  assign load_ready = (state == S_LOAD);
  assign addr_bad   = addr_fault(fetch_addr, ADDR_W);
  assign fetch_acc  = fetch_req && fetch_rdy;
  assign ram_re     = fetch_acc && !addr_bad;
  assign last_beat  = load_valid && (load_last || (ptr == PTR_LAST));

  always_comb begin
    ram_we  = 1'b0;
    wr_word = NOP_WORD;
    case (state)
      S_CLEAR: ram_we = 1'b1;
      S_LOAD: begin
        ram_we  = load_valid;
        wr_word = load_data;
      end
      default: ;
    endcase
  end

`ifdef IMEM_PARITY_EN
  assign ram_wdata  = {^wr_word, wr_word};
  // A stored word plus its parity bit always XORs to zero when intact.
  assign parity_err = fetch_valid && !nop_sel && (^ram_rdata);
`else
  assign ram_wdata  = wr_word;
`endif

  imem_ram #(
    .AddrW(ADDR_W),
    .Width(RAM_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(ptr),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(fetch_addr[ADDR_W+1:2]),
    .rdata_o(ram_rdata)
  );

  // nop_sel only changes on an accepted fetch, so fetch_data holds between fetches.
  assign fetch_data = nop_sel ? NOP_WORD : ram_rdata[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_CLEAR;
      ptr         <= '0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      nop_sel     <= 1'b1;
      load_done   <= 1'b0;
    end else begin
      fetch_valid <= fetch_acc;
      fetch_fault <= fetch_acc && addr_bad;
      load_done   <= 1'b0;
      if (fetch_acc) begin
        nop_sel <= addr_bad;
      end
      case (state)
        S_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == PTR_LAST) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (load_start) begin
            state <= S_LOAD;
            ptr   <= '0;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            ptr <= ptr + 1'b1;
            if (last_beat) begin
              state     <= S_IDLE;
              load_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem.sv
// Directed self-checking bench for instr_mem with a 16-word array.
module tb_instr_mem;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_rdy;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          fetch_fault;
  logic          load_start;
  logic          load_valid;
  logic          load_last;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          load_done;
  logic          parity_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_mem #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_rdy  (fetch_rdy),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .fetch_fault(fetch_fault),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done)
`ifdef IMEM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

`ifndef IMEM_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Single fetch; caller is 1ns past a rising edge with fetch_rdy high.
  task automatic fetch1(input logic [31:0] addr, output logic v, output logic [31:0] d,
                        output logic f, output logic pe);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    @(posedge clk); #1;
    v  = fetch_valid;
    d  = fetch_data;
    f  = fetch_fault;
    pe = parity_err;
    fetch_req = 1'b0;
  endtask

  task automatic wait_ready(output int cyc, output logic lr_seen);
    cyc = 0;
    lr_seen = 1'b0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (load_ready) lr_seen = 1'b1;
    end while (!fetch_rdy && cyc < 100);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last, output logic done);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(posedge clk); #1;
    done = load_done;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic test_reset();
    int   cyc;
    logic lr, v, f, pe;
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (fetch_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_rdy: got %b want 0", fetch_rdy); end
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL rst_lready: got %b want 0", load_ready); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", fetch_valid); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", load_done); end
    n_cmp++; if (fetch_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 00000000", fetch_data); end
    rst_n = 1'b1;
    wait_ready(cyc, lr);
    n_cmp++; if (cyc != 16) begin n_bad++; $display("FAIL clear_len: got %0d want 16", cyc); end
    n_cmp++; if (lr !== 1'b0) begin n_bad++; $display("FAIL clear_lready: got %b want 0", lr); end
    fetch1(32'h0, v, d, f, pe);
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL clr_fetch_valid: got %b want 1", v); end
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL clr_fetch_data: got %h want 00000000", d); end
  endtask

  task automatic test_load();
    logic done;
    int   ndone;
    logic v, f, pe;
    logic [31:0] d;
    logic [31:0] img [3];
    img[0] = 32'h2002_0005;
    img[1] = 32'h2003_000c;
    img[2] = 32'h2067_fff7;
    start_load();
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready: got %b want 1", load_ready); end
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      load_word(img[i], (i == 2), done);
      if (done) ndone++;
      if (i == 2) begin
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL load_done_last: got %b want 1", done); end
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (load_done) ndone++;
    end
    n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL load_done_cnt: got %0d want 1", ndone); end
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL load_exit: got %b want 0", load_ready); end
    fetch1(32'h8, v, d, f, pe);
    n_cmp++; if (v !== 1'b1 || f !== 1'b0) begin n_bad++; $display("FAIL fetch8_vf: got %b%b want 10", v, f); end
    n_cmp++; if (d !== 32'h2067_fff7) begin n_bad++; $display("FAIL fetch8_data: got %h want 2067fff7", d); end
    fetch1(32'hc, v, d, f, pe);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL fetchc_kept: got %h want 00000000", d); end
  endtask

  task automatic test_back_to_back();
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    @(posedge clk); #1;
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_data !== 32'h2002_0005) begin
      n_bad++; $display("FAIL b2b_0: got %b/%h want 1/20020005", fetch_valid, fetch_data); end
    fetch_addr = 32'h4;
    @(posedge clk); #1;
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_data !== 32'h2003_000c) begin
      n_bad++; $display("FAIL b2b_4: got %b/%h want 1/2003000c", fetch_valid, fetch_data); end
    fetch_addr = 32'h8;
    @(posedge clk); #1;
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_data !== 32'h2067_fff7) begin
      n_bad++; $display("FAIL b2b_8: got %b/%h want 1/2067fff7", fetch_valid, fetch_data); end
    fetch_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (fetch_valid !== 1'b0 || fetch_data !== 32'h2067_fff7) begin
      n_bad++; $display("FAIL b2b_hold: got %b/%h want 0/2067fff7", fetch_valid, fetch_data); end
  endtask

  task automatic test_fault();
    logic v, f, pe;
    logic [31:0] d;
    fetch1(32'h6, v, d, f, pe);
    n_cmp++; if (v !== 1'b1 || f !== 1'b1 || d !== 32'h0) begin
      n_bad++; $display("FAIL fault_misalign: got %b%b/%h want 11/00000000", v, f, d); end
    fetch1(32'h8, v, d, f, pe);
    fetch1(32'h40, v, d, f, pe);
    n_cmp++; if (v !== 1'b1 || f !== 1'b1 || d !== 32'h0) begin
      n_bad++; $display("FAIL fault_range: got %b%b/%h want 11/00000000", v, f, d); end
    fetch1(32'h3c, v, d, f, pe);
    n_cmp++; if (f !== 1'b0) begin n_bad++; $display("FAIL fault_top_word: got %b want 0", f); end
    @(posedge clk); #1;
    n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL fault_idle: got %b want 0", fetch_fault); end
  endtask

  task automatic test_load_with_fetch();
    logic done;
    logic v, f, pe;
    logic [31:0] d;
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    @(posedge clk); #1;
    load_start = 1'b0;
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_data !== 32'h2003_000c) begin
      n_bad++; $display("FAIL overlap_old: got %b/%h want 1/2003000c", fetch_valid, fetch_data); end
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL overlap_load: got %b want 1", load_ready); end
    fetch_addr = 32'h0;
    load_word(32'h1111_1111, 1'b0, done);
    n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL drop_req0: got %b want 0", fetch_valid); end
    load_word(32'h2222_2222, 1'b1, done);
    n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL drop_req1: got %b want 0", fetch_valid); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL overlap_done: got %b want 1", done); end
    fetch_req = 1'b0;
    fetch1(32'h4, v, d, f, pe);
    n_cmp++; if (d !== 32'h2222_2222) begin n_bad++; $display("FAIL reload_4: got %h want 22222222", d); end
    fetch1(32'h0, v, d, f, pe);
    n_cmp++; if (d !== 32'h1111_1111) begin n_bad++; $display("FAIL reload_0: got %h want 11111111", d); end
    fetch1(32'h8, v, d, f, pe);
    n_cmp++; if (d !== 32'h2067_fff7) begin n_bad++; $display("FAIL reload_kept: got %h want 2067fff7", d); end
  endtask

  task automatic test_load_full();
    logic done;
    int   ndone;
    logic v, f, pe;
    logic [31:0] d;
    start_load();
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      load_word(32'ha000_0000 + 32'(i), 1'b0, done);
      if (done) ndone++;
    end
    n_cmp++; if (ndone != 1 || done !== 1'b1) begin
      n_bad++; $display("FAIL full_done: got %0d/%b want 1/1", ndone, done); end
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL full_exit: got %b want 0", load_ready); end
    fetch1(32'h3c, v, d, f, pe);
    n_cmp++; if (d !== 32'ha000_000f) begin n_bad++; $display("FAIL full_top: got %h want a000000f", d); end
    fetch1(32'h0, v, d, f, pe);
    n_cmp++; if (d !== 32'ha000_0000) begin n_bad++; $display("FAIL full_bot: got %h want a0000000", d); end
  endtask

  task automatic test_reset_mid_load();
    logic done, lr, v, f, pe;
    int   cyc;
    logic [31:0] d;
    start_load();
    load_word(32'hdead_beef, 1'b0, done);
    load_word(32'h1234_5678, 1'b0, done);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++; if (load_ready !== 1'b0 || fetch_rdy !== 1'b0) begin
      n_bad++; $display("FAIL abort_state: got %b%b want 00", load_ready, fetch_rdy); end
    wait_ready(cyc, lr);
    n_cmp++; if (cyc != 16) begin n_bad++; $display("FAIL reclear_len: got %0d want 16", cyc); end
    fetch1(32'h0, v, d, f, pe);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reclear_0: got %h want 00000000", d); end
    fetch1(32'h3c, v, d, f, pe);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reclear_top: got %h want 00000000", d); end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    logic done, v, f, pe;
    logic [31:0] d;
    start_load();
    load_word(32'h0000_0007, 1'b0, done);
    load_word(32'h8000_0001, 1'b1, done);
    fetch1(32'h4, v, d, f, pe);
    n_cmp++; if (pe !== 1'b0) begin n_bad++; $display("FAIL par_clean: got %b want 0", pe); end
    dut.u_ram.mem[1][DW] = ~dut.u_ram.mem[1][DW];
    fetch1(32'h4, v, d, f, pe);
    n_cmp++; if (pe !== 1'b1 || v !== 1'b1) begin n_bad++; $display("FAIL par_err: got %b%b want 11", pe, v); end
    n_cmp++; if (d !== 32'h8000_0001) begin n_bad++; $display("FAIL par_data: got %h want 80000001", d); end
    fetch1(32'h0, v, d, f, pe);
    n_cmp++; if (pe !== 1'b0) begin n_bad++; $display("FAIL par_other: got %b want 0", pe); end
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
    test_reset();
    test_load();
    test_back_to_back();
    test_fault();
    test_load_with_fetch();
    test_load_full();
    test_reset_mid_load();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
